// File: rtl/mem_stage_pkg.sv
// Shared opcode, funct3 and state definitions for the memory-access stage.
package mem_stage_pkg;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;

    localparam logic [2:0] FUNCT3_LB  = 3'b000;
    localparam logic [2:0] FUNCT3_LH  = 3'b001;
    localparam logic [2:0] FUNCT3_LW  = 3'b010;
    localparam logic [2:0] FUNCT3_LBU = 3'b100;
    localparam logic [2:0] FUNCT3_LHU = 3'b101;
    localparam logic [2:0] FUNCT3_SB  = 3'b000;
    localparam logic [2:0] FUNCT3_SH  = 3'b001;
    localparam logic [2:0] FUNCT3_SW  = 3'b010;

    typedef enum logic [1:0] {
        MEM_IDLE = 2'd0,
        MEM_XFER = 2'd1,
        MEM_DONE = 2'd2
    } mem_state_e;

    // Number of bytes moved by an access of the given funct3.
    function automatic logic [2:0] access_bytes(input logic [2:0] func3);
        case (func3[1:0])
            2'b00:   access_bytes = 3'd1;
            2'b01:   access_bytes = 3'd2;
            default: access_bytes = 3'd4;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_extend.sv
// Sign/zero extension of an assembled little-endian load buffer.
module mem_stage_load_extend #(
    parameter int unsigned XLEN = 32
) (
    input  logic [XLEN-1:0] i_buf,
    input  logic [2:0]      i_func3,
    output logic [XLEN-1:0] o_data
);

    logic w_sext;

    // Select the loaded width and fill the upper bits.
    always_comb begin
        w_sext = ~i_func3[2];
        o_data = i_buf;
        case (i_func3[1:0])
            2'b00:   o_data = {{(XLEN-8){w_sext & i_buf[7]}}, i_buf[7:0]};
            2'b01:   o_data = {{(XLEN-16){w_sext & i_buf[15]}}, i_buf[15:0]};
            default: o_data = i_buf;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory-access stage: byte-serial loads/stores over an arbitrated port.
module mem_stage #(
    parameter int unsigned XLEN   = 32,
    parameter int unsigned ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [6:0]        opcode_i,
    input  logic [2:0]        func3_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [XLEN-1:0]   reg2_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [XLEN-1:0]   wdata_i,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [XLEN-1:0]   wdata_o,
    output logic              stall_o,
    output logic              mem_req_o,
    input  logic              mem_gnt_i,
    output logic [ADDR_W-1:0] mem_a_o,
    output logic              mem_wr_o,
    output logic [7:0]        mem_dout_o,
    input  logic [7:0]        mem_din_i
);

    import mem_stage_pkg::*;

    mem_state_e      r_state, w_state_nxt;
    logic [2:0]      r_iss_cnt, r_rcv_cnt, w_iss_nxt, w_rcv_nxt, w_size;
    logic            r_pend;
    logic [XLEN-1:0] r_buf, w_ext;
    logic            w_is_load, w_is_store, w_issue, w_fire;

    assign w_is_load  = (opcode_i == OP_LOAD);
    assign w_is_store = (opcode_i == OP_STORE);
    assign w_size     = access_bytes(func3_i);
    assign w_issue    = (r_state == MEM_XFER) && (r_iss_cnt < w_size);
    assign w_fire     = w_issue && mem_gnt_i;

    mem_stage_load_extend #(
        .XLEN (XLEN)
    ) u_load_extend (
        .i_buf   (r_buf),
        .i_func3 (func3_i),
        .o_data  (w_ext)
    );

    // Next-state and counter advance.
    always_comb begin
        w_state_nxt = r_state;
        w_iss_nxt   = r_iss_cnt + 3'(w_fire);
        w_rcv_nxt   = r_rcv_cnt + 3'(r_pend);
        case (r_state)
            MEM_IDLE: if (w_is_load || w_is_store) w_state_nxt = MEM_XFER;
            MEM_XFER: begin
                // Loads also wait for the byte issued last, which arrives one cycle later.
                if ((w_iss_nxt == w_size) && (!w_is_load || (w_rcv_nxt == w_size))) begin
                    w_state_nxt = MEM_DONE;
                end
            end
            MEM_DONE: w_state_nxt = MEM_IDLE;
            default:  w_state_nxt = MEM_IDLE;
        endcase
    end

    // Pipeline-side and memory-side outputs; reset forces every strobe low.
    always_comb begin
        stall_o    = !rst && ((r_state == MEM_XFER) ||
                              ((r_state == MEM_IDLE) && (w_is_load || w_is_store)));
        wd_o       = wd_i;
        wreg_o     = !rst && !stall_o && wreg_i;
        wdata_o    = ((r_state == MEM_DONE) && w_is_load) ? w_ext : wdata_i;
        mem_req_o  = !rst && w_issue;
        mem_wr_o   = !rst && w_issue && w_is_store;
        mem_a_o    = '0;
        mem_dout_o = 8'h00;
        if (!rst && (r_state == MEM_XFER)) begin
            mem_a_o = mem_addr_i + ADDR_W'(r_iss_cnt);
        end
        if (mem_wr_o) begin
            mem_dout_o = reg2_i[{r_iss_cnt[1:0], 3'b000} +: 8];
        end
    end

    // State, counters and load byte buffer.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= MEM_IDLE;
            r_iss_cnt <= 3'd0;
            r_rcv_cnt <= 3'd0;
            r_pend    <= 1'b0;
            r_buf     <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                MEM_IDLE: begin
                    r_iss_cnt <= 3'd0;
                    r_rcv_cnt <= 3'd0;
                    r_pend    <= 1'b0;
                end
                MEM_XFER: begin
                    r_iss_cnt <= w_iss_nxt;
                    r_rcv_cnt <= w_rcv_nxt;
                    r_pend    <= w_fire && w_is_load;
                    if (r_pend) begin
                        r_buf[{r_rcv_cnt[1:0], 3'b000} +: 8] <= mem_din_i;
                    end
                end
                default: r_pend <= 1'b0;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage against a byte-addressed memory model.
module tb_mem_stage;

    import mem_stage_pkg::*;

    localparam logic [6:0] OP_ALU = 7'b0110011;

    logic        clk = 1'b0;
    logic        rst;
    logic [6:0]  opcode_i;
    logic [2:0]  func3_i;
    logic [31:0] mem_addr_i, reg2_i, wdata_i, wdata_o, mem_a_o;
    logic [4:0]  wd_i, wd_o;
    logic        wreg_i, wreg_o, stall_o, mem_req_o, mem_gnt_i, mem_wr_o;
    logic [7:0]  mem_dout_o, mem_din_i;

    int unsigned n_vec = 0;
    int unsigned n_bad = 0;
    bit [7:0]    mem [bit [31:0]];

    always #5 clk = ~clk;

    mem_stage #(
        .XLEN   (32),
        .ADDR_W (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .opcode_i   (opcode_i),
        .func3_i    (func3_i),
        .mem_addr_i (mem_addr_i),
        .reg2_i     (reg2_i),
        .wd_i       (wd_i),
        .wreg_i     (wreg_i),
        .wdata_i    (wdata_i),
        .wd_o       (wd_o),
        .wreg_o     (wreg_o),
        .wdata_o    (wdata_o),
        .stall_o    (stall_o),
        .mem_req_o  (mem_req_o),
        .mem_gnt_i  (mem_gnt_i),
        .mem_a_o    (mem_a_o),
        .mem_wr_o   (mem_wr_o),
        .mem_dout_o (mem_dout_o),
        .mem_din_i  (mem_din_i)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    function automatic bit [7:0] mem_rd(input bit [31:0] a);
        if (!mem.exists(a)) mem[a] = 8'($urandom);
        return mem[a];
    endfunction

    function automatic int size_of(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    endfunction

    // Reference load: little-endian assembly, then two's-complement or unsigned value.
    function automatic bit [31:0] exp_load(input bit [31:0] a, input logic [2:0] f3);
        int     n = size_of(f3);
        longint raw = 0;
        for (int i = 0; i < n; i++) raw += longint'(mem_rd(a + 32'(i))) << (8 * i);
        if (!f3[2] && raw >= (longint'(1) << (8 * n - 1))) raw -= longint'(1) << (8 * n);
        return 32'(raw);
    endfunction

    // Drives one instruction from the IDLE cycle until stall_o drops; gmode 0=always grant,
    // 1=alternate starting with a grant, 2=random.
    task automatic run_op(input logic [6:0] op, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] reg2, input logic [4:0] wd, input logic wr,
                          input logic [31:0] wdat, input int gmode,
                          output int xfer_cyc, output int n_wr);
        bit        is_ld = (op == OP_LOAD);
        bit        is_st = (op == OP_STORE);
        int        n     = size_of(f3);
        int        issued = 0;
        int        req_cyc = 0;
        bit        pend = 0;
        bit        seen_req = 0;
        bit        done = 0;
        bit        gnt;
        bit [31:0] pend_a = 0;
        bit [31:0] exp_res;
        xfer_cyc   = 0;
        n_wr       = 0;
        opcode_i   = op;
        func3_i    = f3;
        mem_addr_i = addr;
        reg2_i     = reg2;
        wd_i       = wd;
        wreg_i     = wr;
        wdata_i    = wdat;
        for (int cyc = 0; cyc < 200 && !done; cyc++) begin
            mem_din_i = pend ? mem_rd(pend_a) : 8'($urandom);
            pend = 0;
            gnt  = 0;
            #1;
            if (mem_req_o) seen_req = 1;
            if (seen_req && stall_o) xfer_cyc++;
            if (!stall_o) begin
                done    = 1;
                exp_res = is_ld ? exp_load(addr, f3) : wdat;
                check_eq("wdata", wdata_o, exp_res);
                check_eq("wreg", 32'(wreg_o), 32'(wr));
                check_eq("wd", 32'(wd_o), 32'(wd));
                check_eq("req_done", 32'(mem_req_o), 32'd0);
                if (is_ld || is_st) check_eq("bytes_issued", 32'(issued), 32'(n));
            end else begin
                check_eq("wreg_stall", 32'(wreg_o), 32'd0);
                if (mem_req_o) begin
                    check_eq("addr", mem_a_o, addr + 32'(issued));
                    check_eq("wr", 32'(mem_wr_o), 32'(is_st));
                    check_eq("req_in_range", 32'(issued < n), 32'd1);
                    case (gmode)
                        0:       gnt = 1;
                        1:       gnt = (req_cyc % 2 == 0);
                        default: gnt = ($urandom_range(0, 3) != 0);
                    endcase
                    req_cyc++;
                    if (gnt) begin
                        if (is_st) begin
                            check_eq("dout", 32'(mem_dout_o), 32'(8'(reg2 >> (8 * issued))));
                            mem[addr + 32'(issued)] = 8'(reg2 >> (8 * issued));
                            n_wr++;
                        end else begin
                            pend   = 1;
                            pend_a = addr + 32'(issued);
                        end
                        issued++;
                    end
                end
            end
            mem_gnt_i = gnt;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("timeout", 32'(done), 32'd1);
    endtask

    int xc, nw, iss;

    initial begin
        rst        = 1'b1;
        opcode_i   = OP_LOAD;
        func3_i    = FUNCT3_LW;
        mem_addr_i = 32'h0000_0400;
        reg2_i     = 32'h0;
        wd_i       = 5'd1;
        wreg_i     = 1'b1;
        wdata_i    = 32'h0;
        mem_gnt_i  = 1'b1;
        mem_din_i  = 8'h00;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check_eq("rst_stall", 32'(stall_o), 32'd0);
        check_eq("rst_req", 32'(mem_req_o), 32'd0);
        check_eq("rst_wr", 32'(mem_wr_o), 32'd0);
        check_eq("rst_wreg", 32'(wreg_o), 32'd0);
        check_eq("rst_addr", mem_a_o, 32'd0);
        check_eq("rst_dout", 32'(mem_dout_o), 32'd0);
        opcode_i = OP_ALU;
        rst      = 1'b0;
        @(negedge clk);

        // Passthrough of a non-memory op.
        run_op(OP_ALU, 3'b000, 32'h0, 32'h0, 5'd5, 1'b1, 32'h0000_1234, 0, xc, nw);

        // Word load with continuous grant.
        mem[32'h100] = 8'h78; mem[32'h101] = 8'h56; mem[32'h102] = 8'h34; mem[32'h103] = 8'h12;
        run_op(OP_LOAD, FUNCT3_LW, 32'h100, 32'h0, 5'd7, 1'b1, 32'hDEAD_BEEF, 0, xc, nw);
        check_eq("lw_value_model", exp_load(32'h100, FUNCT3_LW), 32'h1234_5678);
        check_eq("lw_xfer_cycles", 32'(xc), 32'd5);

        // Byte and halfword extension.
        mem[32'h7] = 8'h80;
        run_op(OP_LOAD, FUNCT3_LB, 32'h7, 32'h0, 5'd8, 1'b1, 32'h0, 0, xc, nw);
        run_op(OP_LOAD, FUNCT3_LBU, 32'h7, 32'h0, 5'd8, 1'b1, 32'h0, 2, xc, nw);
        mem[32'h40] = 8'hFF; mem[32'h41] = 8'h7F;
        run_op(OP_LOAD, FUNCT3_LH, 32'h40, 32'h0, 5'd9, 1'b1, 32'h0, 0, xc, nw);

        // Halfword store with alternating grant.
        run_op(OP_STORE, FUNCT3_SH, 32'h20, 32'hAABB_CCDD, 5'd0, 1'b0, 32'h20, 1, xc, nw);
        check_eq("sh_writes", 32'(nw), 32'd2);

        // Word store wrapping the address space, then read it back.
        run_op(OP_STORE, FUNCT3_SW, 32'hFFFF_FFFE, 32'h0BAD_F00D, 5'd0, 1'b0, 32'h0, 0, xc, nw);
        check_eq("sw_writes", 32'(nw), 32'd4);
        run_op(OP_LOAD, FUNCT3_LW, 32'hFFFF_FFFE, 32'h0, 5'd3, 1'b1, 32'h0, 2, xc, nw);

        // Reset after the second byte of a word load.
        opcode_i   = OP_LOAD;
        func3_i    = FUNCT3_LW;
        mem_addr_i = 32'h200;
        mem_gnt_i  = 1'b1;
        iss        = 0;
        for (int c = 0; c < 20 && iss < 2; c++) begin
            #1;
            if (mem_req_o) iss++;
            @(posedge clk);
            @(negedge clk);
        end
        check_eq("rst_mid_issued", 32'(iss), 32'd2);
        rst      = 1'b1;
        opcode_i = OP_ALU;
        #1;
        check_eq("rst_mid_stall", 32'(stall_o), 32'd0);
        check_eq("rst_mid_req", 32'(mem_req_o), 32'd0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            check_eq("post_rst_stall", 32'(stall_o), 32'd0);
            check_eq("post_rst_req", 32'(mem_req_o), 32'd0);
            @(posedge clk);
            @(negedge clk);
        end

        // Randomized mix of loads, stores and ALU ops.
        for (int k = 0; k < 60; k++) begin
            int          sel = $urandom_range(0, 2);
            logic [2:0]  f3;
            logic [31:0] a;
            logic [2:0]  ld_f3 [5] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
            a = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3)))
                                            : (32'h1000 + 32'($urandom_range(0, 63)));
            if (sel == 0) begin
                f3 = ld_f3[$urandom_range(0, 4)];
                run_op(OP_LOAD, f3, a, $urandom, 5'($urandom), 1'($urandom), $urandom, 2, xc, nw);
            end else if (sel == 1) begin
                f3 = 3'($urandom_range(0, 2));
                run_op(OP_STORE, f3, a, $urandom, 5'($urandom), 1'b0, $urandom, 2, xc, nw);
                check_eq("rand_st_writes", 32'(nw), 32'(size_of(f3)));
            end else begin
                run_op(OP_ALU, 3'($urandom), a, $urandom, 5'($urandom), 1'($urandom), $urandom,
                       2, xc, nw);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
